// File: rtl/div_ctrl_pkg.sv
// Shared types for the divider sequencing controller: FSM states, key codes, view select.
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        DIV_WAIT,
        CONV,
        SHOW,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        VIEW_A = 2'b00,
        VIEW_B = 2'b01,
        VIEW_Q = 2'b10,
        VIEW_R = 2'b11
    } view_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_TOGGLE = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal operand accumulator: acc*10+d with digit-count and W-bit range limit.
module dec_accum #(
    parameter int W          = 7,
    parameter int MAX_DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [3:0]   digit,
    output logic [W-1:0] acc,
    output logic [W-1:0] next_acc,
    output logic         accept
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [W+3:0] ACC_MAX = {4'd0, {W{1'b1}}};

    logic [CW-1:0] cnt;
    logic [W+3:0]  sum;

    // Four guard bits hold acc*10+9 without wrap, so the limit test is exact.
    assign sum      = ({4'd0, acc} * (W+4)'(10)) + {{W{1'b0}}, digit};
    assign accept   = (cnt < CW'(MAX_DIGITS)) && (sum <= ACC_MAX);
    assign next_acc = sum[W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (load && accept) begin
            acc <= next_acc;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Keypad -> divider -> bin2bcd sequencing controller.
// Optional divider timeout enabled by defining DIV_WATCHDOG_EN.
module div_seq_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int W           = 7,
    parameter int MAX_DIGITS  = 3,
    parameter int WDOG_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    output logic         bcd_start,
    output logic [W-1:0] bcd_bin,
    input  logic         bcd_done,
    output logic [1:0]   view,
    output logic         err,
    output logic         busy
);
    state_t       state, state_n, ret, ret_n;
    view_t        view_q, view_n;
    logic [W-1:0] div_a_n, div_b_n, bcd_bin_n, q_lat, r_lat, q_lat_n, r_lat_n;
    logic         err_n, div_start_n, bcd_start_n;
    logic         key_ok, do_clear, acc_clr, acc_load, acc_accept, wdog_expire;
    logic [W-1:0] acc, acc_next;

    dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .load     (acc_load),
        .digit    (key_code),
        .acc      (acc),
        .next_acc (acc_next),
        .accept   (acc_accept)
    );

    assign busy   = (state == DIV_WAIT) || (state == CONV);
    assign key_ok = key_valid && !busy;
    assign view   = view_q;

`ifdef DIV_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  wdog_cnt <= '0;
        else if (state != DIV_WAIT) wdog_cnt <= '0;
        else                       wdog_cnt <= wdog_cnt + 1'b1;
    end

    assign wdog_expire = (state == DIV_WAIT) && (wdog_cnt == WDW'(WDOG_CYCLES - 1));
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        ret_n       = ret;
        view_n      = view_q;
        div_a_n     = div_a;
        div_b_n     = div_b;
        bcd_bin_n   = bcd_bin;
        q_lat_n     = q_lat;
        r_lat_n     = r_lat;
        err_n       = err;
        div_start_n = 1'b0;
        bcd_start_n = 1'b0;
        acc_clr     = 1'b0;
        acc_load    = 1'b0;
        do_clear    = 1'b0;

        case (state)
            ENTER_A, ENTER_B: if (key_ok) begin
                if (is_digit(key_code)) begin
                    if (acc_accept) begin
                        acc_load    = 1'b1;
                        bcd_bin_n   = acc_next;
                        bcd_start_n = 1'b1;
                        ret_n       = state;
                        state_n     = CONV;
                    end
                end else if (key_code == KEY_ENTER) begin
                    if (state == ENTER_A) begin
                        div_a_n     = acc;
                        acc_clr     = 1'b1;
                        view_n      = VIEW_B;
                        bcd_bin_n   = '0;
                        bcd_start_n = 1'b1;
                        ret_n       = ENTER_B;
                        state_n     = CONV;
                    end else if (acc == '0) begin
                        err_n   = 1'b1;
                        state_n = ERROR;
                    end else begin
                        div_b_n     = acc;
                        div_start_n = 1'b1;
                        state_n     = DIV_WAIT;
                    end
                end else if (key_code == KEY_CLEAR) begin
                    do_clear = 1'b1;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    q_lat_n     = div_q;
                    r_lat_n     = div_r;
                    view_n      = VIEW_Q;
                    bcd_bin_n   = div_q;
                    bcd_start_n = 1'b1;
                    ret_n       = SHOW;
                    state_n     = CONV;
                end else if (wdog_expire) begin
                    err_n   = 1'b1;
                    state_n = ERROR;
                end
            end
            // A done coincident with our own start pulse belongs to nothing.
            CONV: if (bcd_done && !bcd_start) state_n = ret;
            SHOW: if (key_ok) begin
                if (key_code == KEY_TOGGLE) begin
                    view_n      = (view_q == VIEW_Q) ? VIEW_R : VIEW_Q;
                    bcd_bin_n   = (view_q == VIEW_Q) ? r_lat : q_lat;
                    bcd_start_n = 1'b1;
                    ret_n       = SHOW;
                    state_n     = CONV;
                end else if (key_code == KEY_ENTER || key_code == KEY_CLEAR) begin
                    do_clear = 1'b1;
                end
            end
            ERROR: if (key_ok && key_code == KEY_CLEAR) do_clear = 1'b1;
            default: state_n = ENTER_A;
        endcase

        if (do_clear) begin
            acc_clr     = 1'b1;
            div_a_n     = '0;
            div_b_n     = '0;
            err_n       = 1'b0;
            view_n      = VIEW_A;
            bcd_bin_n   = '0;
            bcd_start_n = 1'b1;
            ret_n       = ENTER_A;
            state_n     = CONV;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTER_A;
            ret       <= ENTER_A;
            view_q    <= VIEW_A;
            div_a     <= '0;
            div_b     <= '0;
            bcd_bin   <= '0;
            q_lat     <= '0;
            r_lat     <= '0;
            err       <= 1'b0;
            div_start <= 1'b0;
            bcd_start <= 1'b0;
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            view_q    <= view_n;
            div_a     <= div_a_n;
            div_b     <= div_b_n;
            bcd_bin   <= bcd_bin_n;
            q_lat     <= q_lat_n;
            r_lat     <= r_lat_n;
            err       <= err_n;
            div_start <= div_start_n;
            bcd_start <= bcd_start_n;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized bench for div_seq_ctrl against a key-level behavioural model.
module tb_div_seq_ctrl;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst, key_valid, div_done, bcd_done;
    logic [3:0]   key_code;
    logic [W-1:0] div_q, div_r;
    logic         div_start, bcd_start, err, busy;
    logic [W-1:0] div_a, div_b, bcd_bin;
    logic [1:0]   view;

    div_seq_ctrl #(.W(W), .MAX_DIGITS(3), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done),
        .div_q(div_q), .div_r(div_r), .bcd_start(bcd_start), .bcd_bin(bcd_bin),
        .bcd_done(bcd_done), .view(view), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_bcd = 0, n_div = 0;
    int div_lat = 0;
    bit div_hold = 0;
    logic [W-1:0] ra, rb;

    // Model state: mode 0 = entering A, 1 = entering B, 2 = showing result, 3 = error
    int m_acc, m_cnt, m_a, m_b, m_q, m_r, m_view, m_err, m_mode, m_bin;
    int e_nbcd, e_ndiv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Start pulses counted per high cycle, so a stretched pulse shows as an extra count.
    always @(negedge clk) begin
        if (bcd_start) n_bcd++;
        if (div_start) n_div++;
    end

    always begin
        @(negedge clk);
        if (div_start && !div_hold) begin
            ra = div_a;
            rb = div_b;
            repeat (div_lat > 0 ? div_lat : int'($urandom_range(1, 6))) @(negedge clk);
            div_q    = (rb == 0) ? '0 : ra / rb;
            div_r    = (rb == 0) ? '0 : ra % rb;
            div_done = 1'b1;
            @(negedge clk);
            div_done = 1'b0;
            div_q    = W'($urandom);
            div_r    = W'($urandom);
        end
    end

    always begin
        @(negedge clk);
        if (bcd_start) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bcd_done = 1'b1;
            @(negedge clk);
            bcd_done = 1'b0;
        end
    end

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_a = 0; m_b = 0; m_view = 0; m_err = 0; m_mode = 0; m_bin = 0;
    endtask

    task automatic model_key(input logic [3:0] k);
        int d;
        d = int'(k);
        e_nbcd = 0;
        e_ndiv = 0;
        if (d == 12 || (d == 10 && m_mode == 2)) begin
            model_clear();
            e_nbcd = 1;
        end else if (d <= 9 && m_mode <= 1) begin
            if (m_cnt < 3 && m_acc * 10 + d <= 127) begin
                m_acc = m_acc * 10 + d; m_cnt++; m_bin = m_acc; e_nbcd = 1;
            end
        end else if (d == 10 && m_mode == 0) begin
            m_a = m_acc; m_acc = 0; m_cnt = 0; m_view = 1; m_mode = 1; m_bin = 0; e_nbcd = 1;
        end else if (d == 10 && m_mode == 1) begin
            if (m_acc == 0) begin
                m_err = 1; m_mode = 3;
            end else begin
                m_b = m_acc; m_q = m_a / m_b; m_r = m_a % m_b;
                m_view = 2; m_mode = 2; m_bin = m_q; e_ndiv = 1; e_nbcd = 1;
            end
        end else if (d == 11 && m_mode == 2) begin
            m_view = (m_view == 2) ? 3 : 2;
            m_bin  = (m_view == 3) ? m_r : m_q;
            e_nbcd = 1;
        end
    endtask

    task automatic key_pulse(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'($urandom);
    endtask

    task automatic settle(input int b0, input int d0);
        int cyc;
        cyc = 0;
        while (busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("settle_timeout", 32'(cyc < 400), 1);
        chk("view", 32'(view), m_view);
        chk("err", 32'(err), m_err);
        chk("div_a", 32'(div_a), m_a);
        chk("div_b", 32'(div_b), m_b);
        chk("bcd_bin", 32'(bcd_bin), m_bin);
        chk("bcd_start_count", n_bcd - b0, e_nbcd);
        chk("div_start_count", n_div - d0, e_ndiv);
    endtask

    task automatic press(input logic [3:0] k);
        int b0, d0;
        b0 = n_bcd;
        d0 = n_div;
        model_key(k);
        key_pulse(k);
        settle(b0, d0);
    endtask

    task automatic press_seq(input logic [3:0] ks [$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    initial begin
        int b0, d0;
        logic [3:0] k;
        int r;
        rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        div_done = 1'b0; bcd_done = 1'b0; div_q = '0; div_r = '0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'({div_start, bcd_start, div_a, div_b, bcd_bin, view, err, busy}), 0);
        @(negedge clk);
        rst = 1'b1;

        // 84 / 12
        press_seq('{4'h8, 4'h4, 4'hA, 4'h1, 4'h2, 4'hA});
        chk("t1_div_a", 32'(div_a), 84);
        chk("t1_div_b", 32'(div_b), 12);
        chk("t1_bcd_q", 32'(bcd_bin), 7);
        chk("t1_view", 32'(view), 2);

        // 100 / 7 then toggle twice
        press_seq('{4'hC, 4'h1, 4'h0, 4'h0, 4'hA, 4'h7, 4'hA});
        chk("t2_q", 32'(bcd_bin), 14);
        press(4'hB);
        chk("t2_view_r", 32'(view), 3);
        chk("t2_r", 32'(bcd_bin), 2);
        press(4'hB);
        chk("t2_back_q", 32'(bcd_bin), 14);

        // Range and digit-count limits
        press_seq('{4'hC, 4'h1, 4'h2, 4'h8});
        chk("t3_range_hold", 32'(bcd_bin), 12);
        press_seq('{4'hC, 4'h1, 4'h0, 4'h0, 4'h5});
        chk("t3_count_hold", 32'(bcd_bin), 100);

        // Divide by zero, ignored keys in error, clear
        press_seq('{4'hC, 4'h5, 4'h0, 4'hA, 4'h0, 4'hA, 4'h5, 4'hA, 4'hB, 4'hE});
        chk("t4_err", 32'(err), 1);
        press(4'hC);
        chk("t4_cleared", 32'({err, view, bcd_bin}), 0);

        // Keys during DIV_WAIT, CLEAR coincident with div_done: all dropped
        press_seq('{4'h9, 4'h5, 4'hA, 4'h7});
        div_lat = 4;
        b0 = n_bcd; d0 = n_div;
        model_key(4'hA);
        key_pulse(4'hA);
        key_pulse(4'h3);
        @(negedge clk);
        key_pulse(4'hC);
        settle(b0, d0);
        chk("t5_q", 32'(bcd_bin), 13);

        // Random key streams
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 72) k = 4'hA;
            else if (r < 84) k = 4'hB;
            else if (r < 92) k = 4'hC;
            else             k = 4'($urandom_range(13, 15));
            div_lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
            press(k);
        end

        // Divider that never answers
        press_seq('{4'hC, 4'h9, 4'hA, 4'h3});
        div_hold = 1'b1;
        d0 = n_div;
        key_pulse(4'hA);
        #1;
        chk("t6_div_start", n_div - d0, 1);
`ifdef DIV_WATCHDOG_EN
        repeat (63) @(negedge clk);
        #1;
        chk("t6_wdog_early", 32'({err, busy}), 32'b01);
        @(negedge clk);
        #1;
        chk("t6_wdog_fire", 32'({err, busy}), 32'b10);
`else
        repeat (1000) @(negedge clk);
        #1;
        chk("t6_wait_busy", 32'({err, busy}), 32'b01);
`endif

        // Reset mid-operation, then a stale done must be ignored
        rst = 1'b0;
        #1;
        chk("t7_reset_outputs", 32'({div_start, bcd_start, div_a, div_b, bcd_bin, view, err, busy}), 0);
        @(negedge clk);
        rst = 1'b1;
        div_hold = 1'b0;
        model_clear();
        b0 = n_bcd;
        div_q = 7'd5; div_done = 1'b1; bcd_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0; bcd_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t7_late_done", 32'({busy, view, bcd_bin}), 0);
        chk("t7_no_conv", n_bcd - b0, 0);
        div_lat = 0;
        press_seq('{4'h4, 4'hA, 4'h2, 4'hA});
        chk("t7_after_reset_q", 32'(bcd_bin), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequencing controller between the debounced/scanned keypad and the restoring divider and bin2bcd datapath.
- Accepts one-cycle key events and assembles decimal operands A and B.
- Rejects divide-by-zero, launches the divider, captures Q/R and schedules every bin2bcd conversion.
- Drives the view selector that tells the display path what is shown.
- Replaces ad-hoc start/edge-detect glue in the divider top level.

Parameters:
W, 7, operand/quotient/remainder width; max operand 2^W-1.
MAX_DIGITS, 3, maximum decimal digits per operand.
WDOG_CYCLES, 64, divider timeout in cycles; used only with DIV_WATCHDOG_EN.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
key_valid  in  1  one-cycle pulse, key_code valid
key_code  in  4  hex key: 0-9 digit, A=ENTER, B=TOGGLE, C=CLEAR, D-F ignored
div_start  out  1  one-cycle divider start pulse
div_a  out  W  dividend, stable from div_start until next operation
div_b  out  W  divisor, same stability rule as div_a
div_done  in  1  divider completion pulse
div_q  in  W  quotient, valid with div_done
div_r  in  W  remainder, valid with div_done
bcd_start  out  1  one-cycle bin2bcd start pulse
bcd_bin  out  W  value to convert, stable while converting
bcd_done  in  1  bin2bcd completion pulse
view  out  2  00=A, 01=B, 10=Q, 11=R
err  out  1  divide-by-zero or timeout flag
busy  out  1  high in DIV_WAIT and CONV; keys dropped while high

Behaviour:
- Reset values: state ENTER_A; all outputs 0 (div_start, bcd_start, div_a, div_b, bcd_bin, view, err, busy); internal acc=0, digit count=0, Q/R latches=0.
- States: ENTER_A, ENTER_B, DIV_WAIT, CONV, SHOW, ERROR. CONV also holds a return-state register.
- Digit d in ENTER_A/ENTER_B: accepted iff count<MAX_DIGITS and acc*10+d <= 2^W-1; compute in W+4 bits.
  - Rejected digit: no state change, no bcd_start.
  - Accepted digit, cycle after key_valid: acc updated; count+1; bcd_bin=new acc; bcd_start=1; state=CONV, return=current state.
- CONV: waits for bcd_done, sampled from the cycle after bcd_start. Next cycle: state=return, busy=0.
- ENTER in ENTER_A: div_a<=acc; acc and count cleared; view=01; bcd_bin=0 converted; return=ENTER_B.
- ENTER in ENTER_B:
  - acc==0: state=ERROR, err=1, no div_start.
  - Otherwise: div_b<=acc; div_start=1 for exactly one cycle; state=DIV_WAIT.
- DIV_WAIT, on div_done: latch div_q/div_r; view=10; bcd_bin=Q; convert; return=SHOW.
- SHOW:
  - TOGGLE flips view 10<->11 and converts R or Q accordingly.
  - ENTER starts a new operation: same as CLEAR.
  - Digits ignored.
- CLEAR, accepted in ENTER_A, ENTER_B, SHOW, ERROR:
  - acc, count, div_a, div_b cleared; err=0; view=00.
  - bcd_bin=0 converted; return=ENTER_A.
- ERROR: err held; only CLEAR exits.
- Simultaneous events:
  - key_valid together with div_done or bcd_done: key dropped, done processed.
  - key_valid with busy=1: dropped.
- Ignored keys: TOGGLE outside SHOW; ENTER in ERROR.
- Keys D-F ignored everywhere.
- Reset mid-operation: immediate return to reset values. A late div_done/bcd_done outside DIV_WAIT/CONV is ignored.

Optional Feature:
DIV_WATCHDOG_EN
- Defined: cycle counter runs in DIV_WAIT, starting the cycle after div_start. If WDOG_CYCLES cycles elapse without div_done: state=ERROR, err=1, busy=0.
- Undefined: DIV_WAIT waits indefinitely and the counter is not instantiated.

Decomposition:
- Package div_ctrl_pkg:
  - state enum
  - key constants KEY_ENTER=4'hA, KEY_TOGGLE=4'hB, KEY_CLEAR=4'hC
  - view enum VIEW_A/B/Q/R
- One sub-module, dec_accum: decimal accumulator with digit count, overflow/limit check, clear, accept output.

Test Plan:
- Reset; keys 8,4,A,1,2,A -> div_a=84, div_b=12, one-cycle div_start. Model returns q=7, r=0 -> view=10, bcd_bin=7, one bcd_start, then SHOW.
- 100/7 with q=14, r=2; TOGGLE -> view=11, bcd_bin=2; TOGGLE -> view=10, bcd_bin=14.
- Digits 1,2,8 -> 128 rejected, acc stays 12, no bcd_start. After CLEAR, digits 1,0,0,5 -> 4th digit rejected, acc=100.
- A=50, B=0, ENTER -> err=1, no div_start; keys 5,A ignored; CLEAR -> err=0, view=00, bcd_bin=0, bcd_start pulse.
- Digit 3 and CLEAR during DIV_WAIT, one coincident with div_done -> all dropped; result displayed normally.
- DIV_WATCHDOG_EN, WDOG_CYCLES=64, div_done never asserted -> err=1 exactly 64 cycles after div_start. Without macro -> busy stays 1 for 1000 cycles.
